// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode, ALU/mux encodings, state encoding and per-state control words.
// JEX state and the jump opcode are only present when MC_JUMP_EN is defined.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10
`ifdef MC_JUMP_EN
    , S_JEX   = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_ADDI);
`ifdef MC_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

  // FETCH carries ir_write/pc_write set; the top gates them with mem_ready.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_RTYPEEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JEX: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bus between the multi-cycle controller and datapath.
interface multicycle_control_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, illegal_op, mem_timeout
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter; expired when count reaches WAIT_LIMIT (0 = never).
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (WAIT_LIMIT != 0) && (count == CW'(WAIT_LIMIT));
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with bounded memory wait.
// Define MC_JUMP_EN to add the JEX state for op 0x02; otherwise 0x02 is illegal.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_o;
  logic   waiting;
  logic   stalled;
  logic   expired;
  logic   timeout;

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign stalled = waiting && !bus.mem_ready;
  assign timeout = stalled && expired;

  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!stalled || timeout),
    .enable  (stalled),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready)  state_next = S_DECODE;
        else if (timeout)   state_next = S_FETCH;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_next = S_JEX;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  state_next = S_MEMWB;
        else if (timeout)   state_next = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready || timeout) state_next = S_FETCH;
      end
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      ctrl_q <= ctrl_for(S_FETCH);
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_for(state_next);
    end
  end

  always_comb begin
    ctrl_o = ctrl_q;
    if (state == S_FETCH) begin
      ctrl_o.ir_write = ctrl_q.ir_write & bus.mem_ready;
      ctrl_o.pc_write = ctrl_q.pc_write & bus.mem_ready;
    end
    if (reset || timeout) ctrl_o = '0;
  end

  assign bus.pc_write      = ctrl_o.pc_write;
  assign bus.pc_write_cond = ctrl_o.pc_write_cond;
  assign bus.pc_src        = ctrl_o.pc_src;
  assign bus.i_or_d        = ctrl_o.i_or_d;
  assign bus.mem_read      = ctrl_o.mem_read;
  assign bus.mem_write     = ctrl_o.mem_write;
  assign bus.ir_write      = ctrl_o.ir_write;
  assign bus.reg_write     = ctrl_o.reg_write;
  assign bus.reg_dst       = ctrl_o.reg_dst;
  assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
  assign bus.alu_src_a     = ctrl_o.alu_src_a;
  assign bus.alu_src_b     = ctrl_o.alu_src_b;
  assign bus.alu_op        = ctrl_o.alu_op;
  assign bus.illegal_op    = !reset && (state == S_DECODE) && !op_legal(bus.op);
  assign bus.mem_timeout   = !reset && timeout;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control against an instruction-level model.
module tb_multicycle_control;
  localparam int WL = 3;

  typedef enum {K_FETCH, K_DECODE, K_ADDR, K_RD, K_LWB, K_WR,
                K_REX, K_RWB, K_BEQ, K_AEX, K_AWB, K_J} step_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control #(.WAIT_LIMIT(WL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  logic [17:0] expq[$];
  step_t       cur = K_FETCH;
  step_t       plan[$];
  int          waited = 0;
  logic [17:0] mon_exp;
  logic [17:0] mon_act;
  logic [5:0]  op_now;

  // Output word: {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
  //               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, mem_timeout}
  function automatic logic [17:0] word(logic pcw, logic pcc, logic [1:0] pcs, logic iod,
                                       logic mr, logic mw, logic irw, logic rw, logic rd,
                                       logic m2r, logic asa, logic [1:0] asb, logic [1:0] aop);
    return {pcw, pcc, pcs, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, 2'b00};
  endfunction

  function automatic logic [17:0] expect_for(step_t s, logic rdy);
    case (s)
      K_FETCH:  return word(rdy, 0, 2'd0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'd1, 2'd0);
      K_DECODE: return word(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0);
      K_ADDR:   return word(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
      K_RD:     return word(0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      K_LWB:    return word(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0);
      K_WR:     return word(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      K_REX:    return word(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2);
      K_RWB:    return word(0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0);
      K_BEQ:    return word(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1);
      K_AEX:    return word(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
      K_AWB:    return word(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
      K_J:      return word(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      default:  return 18'h0;
    endcase
  endfunction

  task automatic make_plan(input logic [5:0] o);
    plan.delete();
    case (o)
      6'h23: begin plan.push_back(K_ADDR); plan.push_back(K_RD); plan.push_back(K_LWB); end
      6'h2B: begin plan.push_back(K_ADDR); plan.push_back(K_WR); end
      6'h00: begin plan.push_back(K_REX); plan.push_back(K_RWB); end
      6'h04: plan.push_back(K_BEQ);
      6'h08: begin plan.push_back(K_AEX); plan.push_back(K_AWB); end
`ifdef MC_JUMP_EN
      6'h02: plan.push_back(K_J);
`endif
      default: ;
    endcase
  endtask

  // Drive one clock of inputs, predict that cycle's outputs, advance the model.
  task automatic step(input logic r, input logic [5:0] o, input logic z, input logic rdy);
    logic [17:0] e;
    reset = r;
    bus.op = o;
    bus.zero = z;
    bus.mem_ready = rdy;
    if (r) begin
      e = '0;
      cur = K_FETCH;
      plan.delete();
      waited = 0;
    end else begin
      e = expect_for(cur, rdy);
      if ((cur == K_FETCH || cur == K_RD || cur == K_WR) && !rdy) begin
        if (WL > 0 && waited == WL) begin
          e = 18'h1;
          cur = K_FETCH;
          plan.delete();
          waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
        if (cur == K_FETCH) begin
          cur = K_DECODE;
        end else begin
          if (cur == K_DECODE) begin
            make_plan(o);
            if (plan.size() == 0) e[1] = 1'b1;
          end
          cur = (plan.size() > 0) ? plan.pop_front() : K_FETCH;
        end
      end
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_exp = expq.pop_front();
      mon_act = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                 bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal_op, bus.mem_timeout};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL ctrl_word t=%0t actual=%b required=%b", $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    int thr;
    reset = 1'b1;
    bus.op = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step(1, 6'h00, 0, 1);
    repeat (5) step(0, 6'h23, 0, 1);
    repeat (4) step(0, 6'h00, 0, 1);
    repeat (3) step(0, 6'h04, 1, 1);
    repeat (4) step(0, 6'h08, 0, 1);
    repeat (4) step(0, 6'h2B, 0, 1);
    repeat (3) step(0, 6'h00, 0, 0);
    repeat (4) step(0, 6'h00, 0, 1);
    repeat (5) step(0, 6'h00, 0, 0);
    repeat (2) step(0, 6'h3F, 0, 1);
    repeat (3) step(0, 6'h02, 0, 1);
    repeat (3) step(0, 6'h2B, 0, 1);
    step(0, 6'h2B, 0, 0);
    step(1, 6'h2B, 0, 0);
    step(0, 6'h2B, 0, 0);
    step(0, 6'h23, 0, 1);
    repeat (2) step(0, 6'h23, 0, 1);
    repeat (5) step(0, 6'h23, 0, 0);
    repeat (4) step(0, 6'h23, 0, 1);

    op_now = 6'h00;
    thr = 90;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: thr = 90;
          1: thr = 50;
          default: thr = 15;
        endcase
      end
      if (cur == K_FETCH) begin
        case ($urandom_range(0, 7))
          0: op_now = 6'h23;
          1: op_now = 6'h2B;
          2: op_now = 6'h00;
          3: op_now = 6'h04;
          4: op_now = 6'h08;
          5: op_now = 6'h02;
          6: op_now = 6'h3F;
          default: op_now = 6'($urandom_range(0, 63));
        endcase
      end
      step(($urandom_range(0, 199) == 0), op_now, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < thr));
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
